// File: rtl/hub75_pkg.sv
// Shared HUB75 constants: default panel geometry, RGB bit positions and the
// receive-side FSM state encoding.
package hub75_pkg;

    localparam int COLS_DEFAULT     = 64;
    localparam int ROW_BITS_DEFAULT = 4;

    // Bit positions inside the 6-bit {R0,G0,B0,R1,G1,B1} pixel pair
    localparam int RGB_R0 = 5;
    localparam int RGB_G0 = 4;
    localparam int RGB_B0 = 3;
    localparam int RGB_R1 = 2;
    localparam int RGB_G1 = 1;
    localparam int RGB_B1 = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rxState_e;

endpackage

// File: rtl/hub75_rx_capture_if.sv
// HUB75 input pins plus the rebuilt framebuffer write stream and status flags.
interface hub75_rx_capture_if import hub75_pkg::*; #(
    parameter int COLS     = COLS_DEFAULT,
    parameter int ROW_BITS = ROW_BITS_DEFAULT
);

    localparam int ADDR_W = ROW_BITS + $clog2(COLS);

    logic                sclk_in;
    logic                lat_in;
    logic                oe_in;
    logic [ROW_BITS-1:0] addr_in;
    logic [5:0]          rgb_in;

    logic                fb_we;
    logic [ADDR_W-1:0]   fb_addr;
    logic [5:0]          fb_wdata;
    logic                row_done;
    logic                frame_done;
    logic                col_err;
    logic                overrun;
    logic                oe_violation;

    modport master (
        output sclk_in, lat_in, oe_in, addr_in, rgb_in,
        input  fb_we, fb_addr, fb_wdata, row_done, frame_done,
               col_err, overrun, oe_violation
    );

    modport slave (
        input  sclk_in, lat_in, oe_in, addr_in, rgb_in,
        output fb_we, fb_addr, fb_wdata, row_done, frame_done,
               col_err, overrun, oe_violation
    );

endinterface

// File: rtl/hub75_in_sync.sv
// Multi-stage synchronizer with a trailing registered copy for rising-edge
// detection; every bit gets the same latency so buses stay aligned.
module hub75_in_sync import hub75_pkg::*; #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[STAGES-1];
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;

endmodule

// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: captures shifted rows into ping-pong line buffers and drains
// each latched row as a framebuffer write burst, flagging protocol errors.
module hub75_rx_capture import hub75_pkg::*; #(
    parameter int COLS        = COLS_DEFAULT,
    parameter int ROW_BITS    = ROW_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    hub75_rx_capture_if.slave bus
);

    localparam int CNT_W  = $clog2(COLS) + 1;
    localparam int COL_W  = $clog2(COLS);
    localparam int BUS_W  = ROW_BITS + 7;
    localparam logic [CNT_W-1:0] COLS_CNT = CNT_W'(COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic             sclkRise, latRise, sclkLevelUnused, latLevelUnused;
    logic [BUS_W-1:0] busS, busRiseUnused;

    hub75_in_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) uSclkSync (
        .clk(clk), .rst(rst), .d_i(bus.sclk_in), .q_o(sclkLevelUnused), .rise_o(sclkRise)
    );
    hub75_in_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) uLatSync (
        .clk(clk), .rst(rst), .d_i(bus.lat_in), .q_o(latLevelUnused), .rise_o(latRise)
    );
    hub75_in_sync #(.WIDTH(BUS_W), .STAGES(SYNC_STAGES)) uBusSync (
        .clk(clk), .rst(rst), .d_i({bus.oe_in, bus.addr_in, bus.rgb_in}),
        .q_o(busS), .rise_o(busRiseUnused)
    );

    logic                oeS;
    logic [ROW_BITS-1:0] addrS;
    logic [5:0]          rgbS;
    assign oeS   = busS[BUS_W-1];
    assign addrS = busS[6 +: ROW_BITS];
    assign rgbS  = busS[5:0];

    logic [5:0]          lineBuf [2][COLS];
    logic [CNT_W-1:0]    colCnt_q;
    logic                excess_q, wrBank_q, colErr_q, overrun_q, oeViol_q;
    logic [ROW_BITS-1:0] rowLat_q;
    rxState_e            state_q, stateD;
    logic [COL_W-1:0]    drainCol_q, drainColD;
    logic                fbWe_q, fbWeD;
    logic [ROW_BITS+COL_W-1:0] fbAddr_q, fbAddrD;
    logic [5:0]          fbWdata_q, fbWdataD;
    logic                last_q, lastD, lastFrame_q, lastFrameD, rowDone_q, frameDone_q;

    // A shift landing in the same cycle as a latch counts toward the latched row
    logic             shiftTake, shiftExcess, excessAfter, commit;
    logic [CNT_W-1:0] cntAfter;
    assign shiftTake   = sclkRise && (colCnt_q < COLS_CNT);
    assign shiftExcess = sclkRise && !shiftTake;
    assign cntAfter    = colCnt_q + {{(CNT_W-1){1'b0}}, shiftTake};
    assign excessAfter = excess_q | shiftExcess;
    assign commit      = latRise && (state_q != ST_DRAIN);

    always_ff @(posedge clk) begin
        if (shiftTake) begin
            lineBuf[wrBank_q][colCnt_q[COL_W-1:0]] <= rgbS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colCnt_q  <= '0;
            excess_q  <= 1'b0;
            wrBank_q  <= 1'b0;
            rowLat_q  <= '0;
            colErr_q  <= 1'b0;
            overrun_q <= 1'b0;
            oeViol_q  <= 1'b0;
        end else begin
            if (latRise) begin
                colCnt_q <= '0;
                excess_q <= 1'b0;
                colErr_q <= (cntAfter != COLS_CNT) || excessAfter;
                if (commit) begin
                    rowLat_q <= addrS;
                    wrBank_q <= ~wrBank_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                colCnt_q <= cntAfter;
                excess_q <= excessAfter;
                colErr_q <= 1'b0;
            end
            if (sclkRise && !oeS) begin
                oeViol_q <= 1'b1;
            end
        end
    end

    // Drain reads the bank that is not being shifted into
    always_comb begin
        stateD     = state_q;
        drainColD  = drainCol_q;
        fbWeD      = 1'b0;
        fbAddrD    = fbAddr_q;
        fbWdataD   = fbWdata_q;
        lastD      = 1'b0;
        lastFrameD = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    stateD    = ST_DRAIN;
                    drainColD = '0;
                end
            end
            ST_DRAIN: begin
                fbWeD    = 1'b1;
                fbAddrD  = {rowLat_q, drainCol_q};
                fbWdataD = lineBuf[~wrBank_q][drainCol_q];
                if (drainCol_q == LAST_COL) begin
                    stateD     = ST_IDLE;
                    lastD      = 1'b1;
                    lastFrameD = (rowLat_q == '1);
                end else begin
                    drainColD = drainCol_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drainCol_q  <= '0;
            fbWe_q      <= 1'b0;
            fbAddr_q    <= '0;
            fbWdata_q   <= '0;
            last_q      <= 1'b0;
            lastFrame_q <= 1'b0;
            rowDone_q   <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= stateD;
            drainCol_q  <= drainColD;
            fbWe_q      <= fbWeD;
            fbAddr_q    <= fbAddrD;
            fbWdata_q   <= fbWdataD;
            last_q      <= lastD;
            lastFrame_q <= lastFrameD;
            rowDone_q   <= last_q;
            frameDone_q <= lastFrame_q;
        end
    end

    assign bus.fb_we        = fbWe_q;
    assign bus.fb_addr      = fbAddr_q;
    assign bus.fb_wdata     = fbWdata_q;
    assign bus.row_done     = rowDone_q;
    assign bus.frame_done   = frameDone_q;
    assign bus.col_err      = colErr_q;
    assign bus.overrun      = overrun_q;
    assign bus.oe_violation = oeViol_q;

endmodule
